// File: rtl/stream_to_host_pkg.sv
// Shared definitions for the stream-to-host bridge: FSM states and default width.
package stream_to_host_pkg;

  localparam int STREAM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order buffer between the upstream FIFO and the host read port.
// Entry e0 is always the head. The caller never pushes when full and never pops when empty.
module stream_skid2
  import stream_to_host_pkg::*;
#(
  parameter int DATA_WIDTH = STREAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] e0, e1;
  logic [1:0]            occ;

  assign head      = e0;
  assign occupancy = occ;

  // Push/pop update. On a simultaneous push and pop the count is unchanged
  // and the new word lands behind anything still held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_to_host.sv
// Bridges a first-word-fall-through FIFO to a host read port. It keeps a
// two-word buffer, counts the words sent in each host file and, when
// WORDS_PER_FILE is non-zero, signals eof once the file quota is reached.
module stream_to_host
  import stream_to_host_pkg::*;
#(
  parameter int DATA_WIDTH     = STREAM_DATA_WIDTH,
  parameter int WORDS_PER_FILE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_V_dout,
  input  logic                  in_V_empty_n,
  output logic                  in_V_read,
  input  logic                  user_r_rden,
  output logic                  user_r_empty,
  output logic [DATA_WIDTH-1:0] user_r_data,
  output logic                  user_r_eof,
  input  logic                  user_r_open,
  output logic [31:0]           words_sent
);

  stream_state_t         state;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [32:0]           committed;
  logic                  quota_ok;
  logic                  accept;
  logic                  last_word;

  // Words already sent plus words already buffered must stay below the
  // quota, so the buffer never holds words that belong to the next file.
  assign committed = {1'b0, words_sent} + {31'd0, occ};
  assign quota_ok  = (WORDS_PER_FILE == 0) || (committed < 33'(WORDS_PER_FILE));
  assign in_V_read = in_V_empty_n && (state == STREAM) && (occ != 2'd2) && quota_ok;

  assign user_r_empty = (occ == 2'd0) || (state != STREAM);
  assign user_r_eof   = (state == DONE);
  assign accept       = user_r_rden && !user_r_empty;
  assign last_word    = (WORDS_PER_FILE != 0) &&
                        (words_sent == 32'(WORDS_PER_FILE - 1));

  stream_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_V_read),
    .pop       (accept),
    .din       (in_V_dout),
    .head      (head),
    .occupancy (occ)
  );

  // File-level FSM; closing the file wins over reaching the quota.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (user_r_open) state <= STREAM;
        STREAM: begin
          if (!user_r_open)            state <= IDLE;
          else if (accept && last_word) state <= DONE;
        end
        DONE:    if (!user_r_open) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Host data register and per-file word counter (wraps at 2^32).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      user_r_data <= '0;
      words_sent  <= 32'd0;
    end else begin
      if (accept) user_r_data <= head;
      if (state == IDLE) words_sent <= 32'd0;
      else if (accept)   words_sent <= words_sent + 32'd1;
    end
  end

endmodule

// File: tb/tb_stream_to_host.sv
// Randomized bench for stream_to_host: two instances (unbounded file and a
// 4-word file) are driven with shared host controls and private upstream
// streams, and compared every cycle against a pointer-based model.
module tb_stream_to_host;

  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, rden, open;
  logic [1:0]    empty_n, rd, emp, eof, avail;
  logic [DW-1:0] dout [2];
  logic [DW-1:0] data [2];
  logic [31:0]   ws   [2];

  stream_to_host #(.DATA_WIDTH(DW), .WORDS_PER_FILE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_V_dout(dout[0]), .in_V_empty_n(empty_n[0]),
    .in_V_read(rd[0]), .user_r_rden(rden), .user_r_empty(emp[0]), .user_r_data(data[0]),
    .user_r_eof(eof[0]), .user_r_open(open), .words_sent(ws[0]));

  stream_to_host #(.DATA_WIDTH(DW), .WORDS_PER_FILE(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_V_dout(dout[1]), .in_V_empty_n(empty_n[1]),
    .in_V_read(rd[1]), .user_r_rden(rden), .user_r_empty(emp[1]), .user_r_data(data[1]),
    .user_r_eof(eof[1]), .user_r_open(open), .words_sent(ws[1]));

  // Model: up_mem holds every word ever offered upstream. up_rd counts words
  // taken from upstream, dl counts words delivered (or discarded), so the
  // internal buffer is exactly up_mem[dl .. up_rd-1].
  logic [DW-1:0] up_mem [2][DEPTH];
  int            up_wr [2], up_rd [2], dl [2];
  int            m_st  [2];            // 0 closed, 1 streaming, 2 file complete
  logic [31:0]   m_ws  [2];
  logic [DW-1:0] m_data[2];
  int            wpf   [2] = '{0, 4};

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic offer(input int k, input logic [DW-1:0] w);
    if (up_wr[k] < DEPTH) begin
      up_mem[k][up_wr[k]] = w;
      up_wr[k]++;
    end
  endtask

  // One clock: called at negedge with rden/open/reset_n/avail already set.
  task automatic cycle();
    logic [1:0] xr, xe;
    for (int k = 0; k < 2; k++) begin
      empty_n[k] = avail[k] && (up_rd[k] < up_wr[k]);
      dout[k]    = empty_n[k] ? up_mem[k][up_rd[k]] : DW'($urandom);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      int occ;
      occ   = up_rd[k] - dl[k];
      xr[k] = empty_n[k] && m_st[k] == 1 && occ < 2 &&
              (wpf[k] == 0 || longint'(m_ws[k]) + occ < wpf[k]);
      xe[k] = (occ == 0) || (m_st[k] != 1);
      chk($sformatf("in_read%0d", k), 64'(rd[k]), 64'(xr[k]));
      chk($sformatf("empty%0d", k), 64'(emp[k]), 64'(xe[k]));
      chk($sformatf("eof%0d", k), 64'(eof[k]), 64'(m_st[k] == 2));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      logic acc;
      if (xr[k]) up_rd[k]++;
      if (!reset_n) begin
        dl[k] = up_rd[k]; m_st[k] = 0; m_ws[k] = 0; m_data[k] = '0;
      end else begin
        acc = rden && !xe[k];
        if (acc) begin
          m_data[k] = up_mem[k][dl[k]];
          dl[k]++;
        end
        case (m_st[k])
          0: begin m_ws[k] = 0; if (open) m_st[k] = 1; end
          1: begin
            if (acc) m_ws[k] = m_ws[k] + 1;
            if (!open) m_st[k] = 0;
            else if (wpf[k] != 0 && acc && m_ws[k] == 32'(wpf[k])) m_st[k] = 2;
          end
          default: if (!open) m_st[k] = 0;
        endcase
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("data%0d", k), 64'(data[k]), 64'(m_data[k]));
      chk($sformatf("words_sent%0d", k), 64'(ws[k]), 64'(m_ws[k]));
    end
  endtask

  task automatic run(input int n, input logic r, input logic o);
    rden = r; open = o;
    repeat (n) cycle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      up_wr[k] = 0; up_rd[k] = 0; dl[k] = 0; m_st[k] = 0; m_ws[k] = 0; m_data[k] = '0;
    end
    reset_n = 1'b0; rden = 1'b0; open = 1'b0; avail = 2'b11;
    empty_n = 2'b00; dout[0] = '0; dout[1] = '0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_empty0", 64'(emp[0]), 64'd1);
    chk("rst_data1", 64'(data[1]), 64'd0);
    reset_n = 1'b1;

    // Three words, host reading every cycle.
    for (int k = 0; k < 2; k++) begin offer(k, 'hA1); offer(k, 'hA2); offer(k, 'hA3); end
    run(8, 1'b1, 1'b1);
    chk("seq_last0", 64'(data[0]), 64'hA3);
    chk("seq_count0", 64'(ws[0]), 64'd3);

    // Host stalls with upstream non-empty: buffer fills to two, then fetch stops.
    for (int k = 0; k < 2; k++) for (int i = 0; i < 5; i++) offer(k, 'hB0 + i);
    run(6, 1'b0, 1'b1);
    chk("stall_left0", 64'(up_wr[0] - up_rd[0]), 64'd3);
    // Instance 1 reaches its 4-word quota, then rden while empty is ignored.
    run(6, 1'b1, 1'b1);
    chk("quota_eof1", 64'(eof[1]), 64'd1);
    chk("quota_count1", 64'(ws[1]), 64'd4);
    run(3, 1'b1, 1'b1);
    // Reopen: remaining words go to the next file, count restarts.
    run(2, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);
    chk("reopen_count1", 64'(ws[1]), 64'd1);
    chk("reopen_data1", 64'(data[1]), 64'hB1);
    run(6, 1'b1, 1'b1);

    // Close with one word buffered, reopen: that word comes out first.
    for (int k = 0; k < 2; k++) offer(k, 'hC0);
    run(3, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) offer(k, 'hC1);
    run(2, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);

    // Reset with the buffer full, then traffic resumes.
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) offer(k, 'hD0 + i);
    run(2, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1);
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    chk("mid_rst_empty0", 64'(emp[0]), 64'd1);
    chk("mid_rst_data0", 64'(data[0]), 64'd0);
    run(1, 1'b0, 1'b0);
    run(8, 1'b1, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++)
        if (up_wr[k] - up_rd[k] < 4 && $urandom_range(0, 1) == 0) offer(k, DW'($urandom));
      avail   = 2'($urandom);
      rden    = ($urandom_range(0, 3) != 0);
      open    = ($urandom_range(0, 15) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_to_host.md
STREAM_TO_HOST -- requirements
Module: stream_to_host

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of stream and host data.
REQ-002 SHALL have parameter WORDS_PER_FILE, default 0, words per host file before eof; 0 = unbounded, eof never asserted.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_V_dout  input  DATA_WIDTH  upstream FIFO head word (first-word-fall-through), valid while in_V_empty_n=1.
REQ-006 SHALL have port in_V_empty_n  input  1  upstream FIFO has a word.
REQ-007 SHALL have port in_V_read  output  1  pop upstream head at this edge.
REQ-008 SHALL have port user_r_rden  input  1  host read strobe.
REQ-009 SHALL have port user_r_empty  output  1  no word available to host.
REQ-010 SHALL have port user_r_data  output  DATA_WIDTH  word returned to host, valid the cycle after an accepted rden.
REQ-011 SHALL have port user_r_eof  output  1  end-of-file to host.
REQ-012 SHALL have port user_r_open  input  1  host file open.
REQ-013 SHALL have port words_sent  output  32  words delivered in current file.

Function
REQ-014 SHALL hold a 2-entry internal buffer, occupancy 0..2.
REQ-015 SHALL drive in_V_read = in_V_empty_n AND state=STREAM AND occupancy<2 AND (WORDS_PER_FILE=0 OR words_sent+occupancy<WORDS_PER_FILE), combinationally from registered state.
REQ-016 SHALL write in_V_dout into the buffer tail on every edge where in_V_read=1.
REQ-017 SHALL drive user_r_empty=1 when occupancy=0 or state≠STREAM, else 0.
REQ-018 SHALL accept rden only when user_r_empty=0; on accept, load head into user_r_data register, pop head, increment words_sent; one-cycle latency rden->data.
REQ-019 SHALL ignore rden while user_r_empty=1: no pop, user_r_data and words_sent unchanged.
REQ-020 SHALL hold user_r_data between accepted reads.
REQ-021 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve word order.
REQ-022 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-023 SHALL transition IDLE->STREAM when user_r_open=1.
REQ-024 SHALL transition STREAM->DONE on the edge where words_sent becomes WORDS_PER_FILE (WORDS_PER_FILE>0 only).
REQ-025 SHALL transition STREAM->IDLE or DONE->IDLE when user_r_open=0.
REQ-026 SHALL assert user_r_eof=1 only in DONE, with user_r_empty=1.
REQ-027 SHALL, in IDLE, clear words_sent to 0 and halt fetching while retaining buffered words for the next file.
REQ-028 SHALL count words_sent modulo 2^32 when WORDS_PER_FILE=0.

Reset
REQ-029 SHALL, on reset_n=0 at a clock edge, set state IDLE, occupancy 0, user_r_data 0, words_sent 0, user_r_eof 0, in_V_read 0, user_r_empty 1.
REQ-030 SHALL, on reset asserted mid-transfer, discard buffered words; subsequent upstream words flow normally after release.

Structure
REQ-031 SHALL place the FSM state enumeration and the DATA_WIDTH default in the shared stream package.
REQ-032 SHALL implement the 2-entry buffer as sub-module stream_skid2 (push/pop/head/occupancy); FSM, counters and host interface stay in stream_to_host.

Verification
REQ-033 Bench SHALL cover: open=1, upstream words 0xA1,0xA2,0xA3, rden every cycle -> data 0xA1,0xA2,0xA3 on the cycles after each accepted rden; no word dropped or duplicated.
REQ-034 Bench SHALL cover: host stalls (rden=0) with upstream non-empty -> exactly 2 words popped, in_V_read=0 thereafter until the next rden.
REQ-035 Bench SHALL cover: WORDS_PER_FILE=4, 6 upstream words -> 4 delivered, then eof=1 and empty=1; upstream keeps 2 words; open 0->1 -> remaining 2 delivered, words_sent restarts at 1.
REQ-036 Bench SHALL cover: rden while empty=1 -> user_r_data and words_sent unchanged.
REQ-037 Bench SHALL cover: reset_n=0 for 1 cycle with occupancy 2 -> empty=1, words_sent=0, data=0 next cycle; later words delivered correctly.
REQ-038 Bench SHALL cover: open=0 mid-stream with 1 word buffered -> no fetch, empty=1; reopen -> buffered word delivered first.
